// File: rtl/my_module_if.sv
// Pixel stream bundle between the RGB stage and the grey converter.
// The master side drives pixels and framing; the slave side returns grey words and debug state.
interface my_module_if #(
    parameter int num_rows     = 32,
    parameter int num_cols     = 32,
    parameter int num_bits_rgb = 12,
    parameter int output_width = 16
);
    localparam int cnt_w = $clog2(num_rows * num_cols + 1);

    logic [num_bits_rgb-1:0]     red_input;
    logic [num_bits_rgb-1:0]     green_input;
    logic [num_bits_rgb-1:0]     blue_input;
    logic [$clog2(num_rows)-1:0] x_pos;
    logic [$clog2(num_cols)-1:0] y_pos;
    logic                        f_val;
    logic                        d_val;

    logic [output_width-1:0]     data_out1;
    logic [output_width-1:0]     data_out2;
    logic [num_bits_rgb-1:0]     grey_check;

    // Debug observation of the frame tracker
    logic [cnt_w-1:0]            pix_cnt;
    logic                        frame_done;
    logic [$clog2(num_rows)-1:0] dbg_x;
    logic [$clog2(num_cols)-1:0] dbg_y;

    modport master (
        output red_input, green_input, blue_input, x_pos, y_pos, f_val, d_val,
        input  data_out1, data_out2, grey_check, pix_cnt, frame_done, dbg_x, dbg_y
    );

    modport slave (
        input  red_input, green_input, blue_input, x_pos, y_pos, f_val, d_val,
        output data_out1, data_out2, grey_check, pix_cnt, frame_done, dbg_x, dbg_y
    );
endinterface

// File: rtl/my_module.sv
// Streaming RGB-to-greyscale converter: zero-latency luminance datapath packed for the
// SDRAM write ports, plus a registered frame tracker used for debug only.
module my_module #(
    parameter int num_rows        = 32,
    parameter int num_cols        = 32,
    parameter int full_frame_rows = 36,
    parameter int full_frame_cols = 36,
    parameter int num_bits_rgb    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    my_module_if.slave  bus
);
    localparam int max_pix      = num_rows * num_cols;
    localparam int cnt_w        = $clog2(max_pix + 1);
    localparam int raster_total = full_frame_rows * full_frame_cols;
    localparam int raster_w     = $clog2(raster_total);
    localparam int sum_w        = num_bits_rgb + 8;

    localparam logic [cnt_w-1:0]    cnt_max     = cnt_w'(max_pix);
    localparam logic [cnt_w-1:0]    cnt_one     = cnt_w'(1'b1);
    localparam logic [raster_w-1:0] raster_last = raster_w'(raster_total - 1);
    localparam logic [raster_w-1:0] raster_one  = raster_w'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } frame_state_t;

    // Weights sum to 256 so the shifted result always fits the channel width.
    function automatic logic [num_bits_rgb-1:0] luma(
        input logic [num_bits_rgb-1:0] r,
        input logic [num_bits_rgb-1:0] g,
        input logic [num_bits_rgb-1:0] b
    );
        logic [sum_w-1:0] acc;
        acc = sum_w'(r) * sum_w'(8'd77)
            + sum_w'(g) * sum_w'(8'd150)
            + sum_w'(b) * sum_w'(8'd29);
        return num_bits_rgb'(acc >> 8);
    endfunction

    logic [num_bits_rgb-1:0]     grey_s;
    logic [num_bits_rgb-1:0]     grey_gated_s;
    frame_state_t                state_r;
    logic [cnt_w-1:0]            pix_cnt_r;
    logic [raster_w-1:0]         raster_r;
    logic                        frame_done_r;
    logic [$clog2(num_rows)-1:0] dbg_x_r;
    logic [$clog2(num_cols)-1:0] dbg_y_r;

    // Grey value, forced to zero outside the active area and while in reset
    always_comb begin
        grey_s       = luma(bus.red_input, bus.green_input, bus.blue_input);
        grey_gated_s = {num_bits_rgb{1'b0}};
        if (rst_n && bus.d_val) begin
            grey_gated_s = grey_s;
        end else begin
            grey_gated_s = {num_bits_rgb{1'b0}};
        end
    end

    assign bus.grey_check = grey_gated_s;
    assign bus.data_out1  = {1'b0, grey_gated_s[11:7], grey_gated_s[11:2]};
    assign bus.data_out2  = {1'b0, grey_gated_s[6:2],  grey_gated_s[11:2]};

    // Frame tracker: valid-pixel count and raster position since the last f_val pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pix_cnt_r    <= {cnt_w{1'b0}};
            raster_r     <= {raster_w{1'b0}};
            frame_done_r <= 1'b0;
        end else if (bus.f_val) begin
            // The f_val edge is raster cycle 0; clear wins over a coincident d_val.
            state_r      <= ST_ACTIVE;
            pix_cnt_r    <= {cnt_w{1'b0}};
            raster_r     <= raster_one;
            frame_done_r <= 1'b0;
        end else begin
            if (bus.d_val && (pix_cnt_r != cnt_max)) begin
                pix_cnt_r <= pix_cnt_r + cnt_one;
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_ACTIVE: begin
                    if (raster_r == raster_last) begin
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                    end else begin
                        raster_r <= raster_r + raster_one;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Position of the most recent valid pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_x_r <= '0;
            dbg_y_r <= '0;
        end else if (bus.d_val) begin
            dbg_x_r <= bus.x_pos;
            dbg_y_r <= bus.y_pos;
        end else begin
            dbg_x_r <= dbg_x_r;
            dbg_y_r <= dbg_y_r;
        end
    end

    assign bus.pix_cnt    = pix_cnt_r;
    assign bus.frame_done = frame_done_r;
    assign bus.dbg_x      = dbg_x_r;
    assign bus.dbg_y      = dbg_y_r;

endmodule

// File: tb/tb_my_module.sv
// Self-checking bench for my_module: directed corner pixels, reset behaviour and a full
// 36x36 raster of random pixels compared against an arithmetic luminance model.
module tb_my_module;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_cnt;

    my_module_if bus ();

    my_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grey(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic int model_out1(input int gv);
        return ((gv / 128) % 32) * 1024 + gv / 4;
    endfunction

    function automatic int model_out2(input int gv);
        return ((gv / 4) % 32) * 1024 + gv / 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic apply(input int r, input int g, input int b, input logic dv, input logic fv,
                         input int x, input int y);
        bus.red_input   = 12'(r);
        bus.green_input = 12'(g);
        bus.blue_input  = 12'(b);
        bus.d_val       = dv;
        bus.f_val       = fv;
        bus.x_pos       = 5'(x);
        bus.y_pos       = 5'(y);
    endtask

    // Checks the combinational outputs for the pixel currently presented
    task automatic chk_pix(input string tag);
        int gv;
        gv = 0;
        if (rst_n && bus.d_val)
            gv = model_grey(int'(bus.red_input), int'(bus.green_input), int'(bus.blue_input));
        chk({tag, "_grey"}, 32'(bus.grey_check), 32'(gv));
        chk({tag, "_out1"}, 32'(bus.data_out1), 32'(gv == 0 ? 0 : model_out1(gv)));
        chk({tag, "_out2"}, 32'(bus.data_out2), 32'(gv == 0 ? 0 : model_out2(gv)));
    endtask

    // Advance one clock edge, updating the valid-pixel count model first
    task automatic tick();
        if (!rst_n)                             exp_cnt = 0;
        else if (bus.f_val)                     exp_cnt = 0;
        else if (bus.d_val && exp_cnt < 1024)   exp_cnt = exp_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int r; int g; int b; logic dv; int grey; int o1; int o2;
    } vec_t;

    initial begin
        vec_t vecs[7];
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;

        vecs[0] = '{32'hFFF, 32'hFFF, 32'hFFF, 1'b1, 32'hFFF, 32'h7FFF, 32'h7FFF};
        vecs[1] = '{32'hFFF, 32'h000, 32'h000, 1'b1, 32'h4CF, 32'h2533, 32'h4D33};
        vecs[2] = '{32'h000, 32'hFFF, 32'h000, 1'b1, 32'h95F, 32'h4A57, 32'h5E57};
        vecs[3] = '{32'h000, 32'h000, 32'hFFF, 1'b1, 32'h1CF, 32'h0C73, 32'h4C73};
        vecs[4] = '{32'h000, 32'h000, 32'h000, 1'b1, 32'h000, 32'h0000, 32'h0000};
        vecs[5] = '{32'hFFF, 32'hFFF, 32'hFFF, 1'b0, 32'h000, 32'h0000, 32'h0000};
        vecs[6] = '{32'h123, 32'h456, 32'h789, 1'b0, 32'h000, 32'h0000, 32'h0000};

        // Reset held with a bright valid pixel on the inputs
        rst_n = 1'b0;
        apply(32'hFFF, 32'hFFF, 32'hFFF, 1'b1, 1'b0, 0, 0);
        #2;
        chk("rst_grey", 32'(bus.grey_check), 32'h0);
        chk("rst_out1", 32'(bus.data_out1), 32'h0);
        chk("rst_out2", 32'(bus.data_out2), 32'h0);
        tick();
        tick();
        chk("rst_cnt", 32'(bus.pix_cnt), 32'h0);
        chk("rst_done", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        apply(0, 0, 0, 1'b0, 1'b0, 0, 0);
        tick();

        // Directed corner pixels with hand-computed expectations
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].dv, 1'b0, 0, 0);
            #2;
            chk($sformatf("dir%0d_grey", i), 32'(bus.grey_check), 32'(vecs[i].grey));
            chk($sformatf("dir%0d_out1", i), 32'(bus.data_out1), 32'(vecs[i].o1));
            chk($sformatf("dir%0d_out2", i), 32'(bus.data_out2), 32'(vecs[i].o2));
            tick();
        end
        chk("dir_cnt", 32'(bus.pix_cnt), 32'(exp_cnt));

        // Asynchronous reset mid-stream, then resume
        apply(32'hFFF, 32'hFFF, 32'hFFF, 1'b1, 1'b0, 3, 4);
        #2;
        chk("mid_pre_grey", 32'(bus.grey_check), 32'hFFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grey", 32'(bus.grey_check), 32'h0);
        chk("mid_rst_out1", 32'(bus.data_out1), 32'h0);
        chk("mid_rst_cnt", 32'(bus.pix_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        #2;
        chk("mid_rel_out1", 32'(bus.data_out1), 32'h7FFF);
        chk("mid_rel_out2", 32'(bus.data_out2), 32'h7FFF);
        tick();
        chk("mid_rel_cnt", 32'(bus.pix_cnt), 32'(exp_cnt));

        // Random pixels with random d_val
        for (int i = 0; i < 60; i++) begin
            apply(int'($urandom_range(4095)), int'($urandom_range(4095)), int'($urandom_range(4095)),
                  1'($urandom_range(1)), 1'b0, int'($urandom_range(31)), int'($urandom_range(31)));
            #2;
            chk_pix($sformatf("rnd%0d", i));
            tick();
        end
        chk("rnd_cnt", 32'(bus.pix_cnt), 32'(exp_cnt));

        // f_val and d_val together: clear wins
        apply(32'h555, 32'hAAA, 32'h333, 1'b1, 1'b1, 0, 0);
        tick();
        chk("clear_wins_cnt", 32'(bus.pix_cnt), 32'h0);

        // Full 36x36 raster with 2-pixel border, random garbage on border pixels
        for (int k = 0; k < 1296; k++) begin
            int row;
            int col;
            logic act;
            row = k / 36;
            col = k % 36;
            act = (row >= 2 && row < 34 && col >= 2 && col < 34);
            apply(int'($urandom_range(4095)), int'($urandom_range(4095)), int'($urandom_range(4095)),
                  act, (k == 0), act ? row - 2 : 0, act ? col - 2 : 0);
            #2;
            chk_pix($sformatf("frm_r%0d_c%0d", row, col));
            if (k == 700) chk("frm_mid_done", 32'(bus.frame_done), 32'h0);
            tick();
        end
        apply(0, 0, 0, 1'b0, 1'b0, 0, 0);
        #2;
        chk("frm_cnt", 32'(bus.pix_cnt), 32'(exp_cnt));
        chk("frm_cnt_1024", 32'(bus.pix_cnt), 32'd1024);
        chk("frm_done", 32'(bus.frame_done), 32'h1);
        chk("frm_last_x", 32'(bus.dbg_x), 32'd31);
        chk("frm_last_y", 32'(bus.dbg_y), 32'd31);

        // Counter saturates past a full frame
        for (int i = 0; i < 5; i++) begin
            apply(int'($urandom_range(4095)), int'($urandom_range(4095)), int'($urandom_range(4095)),
                  1'b1, 1'b0, 1, 1);
            #2;
            chk_pix($sformatf("sat%0d", i));
            tick();
        end
        chk("sat_cnt", 32'(bus.pix_cnt), 32'd1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
